// File: rtl/physics_pkg.sv
// Shared scan state encoding and fixed-point constants for the collision scheduler.
package physics_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL_X,
    ST_MUL_Y,
    ST_MUL_R,
    ST_CMP,
    ST_REPORT,
    ST_DONE
  } scan_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int FRAC_BITS = DEF_WIDTH / 2;
  localparam int RADIUS_W  = 7;

  function automatic int frac_bits(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/pair_counter.sv
// Walks (i, j) through every unordered pair with i < j in lexicographic order.
module pair_counter #(
  parameter int NUM_BODIES = 8,
  parameter int IDX_W      = $clog2(NUM_BODIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BODIES - 2);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BODIES - 1);

  logic [IDX_W-1:0] i_q, j_q;

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == LAST_I) && (j_q == LAST_J);

  // Advancing past the final pair is a no-op; the caller moves to DONE instead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
    end else if (clear) begin
      i_q <= '0;
      j_q <= IDX_W'(1);
    end else if (advance && !last) begin
      if (j_q != LAST_J) begin
        j_q <= j_q + IDX_W'(1);
      end else begin
        i_q <= i_q + IDX_W'(1);
        j_q <= i_q + IDX_W'(2);
      end
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Serial pairwise collision scan: one shared multiplier forms dx^2, dy^2 and (rA+rB)^2,
// hits leave through a valid/ready port (valid held with stable indices until ready).
module collision_scheduler
  import physics_pkg::*;
#(
  parameter int NUM_BODIES = 8,
  parameter int WIDTH      = 32,
  parameter int IDX_W      = $clog2(NUM_BODIES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      rd_idx_a,
  output logic [IDX_W-1:0]      rd_idx_b,
  input  logic [1:0][WIDTH-1:0] loc_a,
  input  logic [1:0][WIDTH-1:0] loc_b,
  input  logic [RADIUS_W-1:0]   radius_a,
  input  logic [RADIUS_W-1:0]   radius_b,
  input  logic [WIDTH-1:0]      mass_a,
  input  logic [WIDTH-1:0]      mass_b,
  output logic [WIDTH:0]        mul_a,
  output logic [WIDTH:0]        mul_b,
  input  logic [2*WIDTH+1:0]    mul_result,
  output logic                  hit_valid,
  input  logic                  hit_ready,
  output logic [IDX_W-1:0]      hit_idx_a,
  output logic [IDX_W-1:0]      hit_idx_b,
  output logic [2:0]            dbg_state
);

  // Dropping 2*FRAC bits turns the fixed-point d^2 into an integer comparable with r^2.
  localparam int CMP_LO = 2 * frac_bits(WIDTH);
  localparam int CMP_W  = 2 * WIDTH + 3 - CMP_LO;

  scan_state_t          state_q, state_d;
  logic [WIDTH:0]       dx_q, dy_q;
  logic [RADIUS_W:0]    rsum_q;
  logic                 active_q;
  logic [2*WIDTH+2:0]   acc_q;
  logic [15:0]          rsq_q;
  logic                 hit_valid_q;
  logic [IDX_W-1:0]     hit_idx_a_q, hit_idx_b_q;
  logic                 clear, advance, last, hit;
  logic [IDX_W-1:0]     idx_i, idx_j;

  pair_counter #(.NUM_BODIES(NUM_BODIES), .IDX_W(IDX_W)) u_pairs (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .i      (idx_i),
    .j      (idx_j),
    .last   (last)
  );

  assign rd_idx_a  = idx_i;
  assign rd_idx_b  = idx_j;
  assign hit_valid = hit_valid_q;
  assign hit_idx_a = hit_idx_a_q;
  assign hit_idx_b = hit_idx_b_q;
  assign dbg_state = state_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign hit       = active_q && (acc_q[2*WIDTH+2:CMP_LO] <= CMP_W'(rsq_q));

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_MUL_X;
      ST_MUL_X: begin
        mul_a   = dx_q;
        mul_b   = dx_q;
        state_d = ST_MUL_Y;
      end
      ST_MUL_Y: begin
        mul_a   = dy_q;
        mul_b   = dy_q;
        state_d = ST_MUL_R;
      end
      ST_MUL_R: begin
        mul_a   = (WIDTH+1)'(rsum_q);
        mul_b   = (WIDTH+1)'(rsum_q);
        state_d = ST_CMP;
      end
      ST_CMP: begin
        if (hit) begin
          state_d = ST_REPORT;
        end else begin
          advance = 1'b1;
          state_d = last ? ST_DONE : ST_LOAD;
        end
      end
      ST_REPORT: begin
        if (hit_valid_q && hit_ready) begin
          advance = 1'b1;
          state_d = last ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_q        <= '0;
      dy_q        <= '0;
      rsum_q      <= '0;
      active_q    <= 1'b0;
      acc_q       <= '0;
      rsq_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_a_q <= '0;
      hit_idx_b_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          dx_q     <= {loc_a[1][WIDTH-1], loc_a[1]} - {loc_b[1][WIDTH-1], loc_b[1]};
          dy_q     <= {loc_a[0][WIDTH-1], loc_a[0]} - {loc_b[0][WIDTH-1], loc_b[0]};
          rsum_q   <= {1'b0, radius_a} + {1'b0, radius_b};
          active_q <= (mass_a != '0) && (mass_b != '0);
        end
        ST_MUL_X: acc_q <= {1'b0, mul_result};
        ST_MUL_Y: acc_q <= acc_q + {1'b0, mul_result};
        ST_MUL_R: rsq_q <= mul_result[15:0];
        ST_CMP: begin
          if (hit) begin
            hit_valid_q <= 1'b1;
            hit_idx_a_q <= idx_i;
            hit_idx_b_q <= idx_j;
          end
        end
        ST_REPORT: begin
          if (hit_valid_q && hit_ready) hit_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: a 2-body and a 4-body instance, each fed from a body table
// and a behavioural multiplier, checked against an arithmetic collision model.
module tb_collision_scheduler;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 2-body instance ----------------
  logic                 start2 = 1'b0, hr2 = 1'b0;
  logic                 busy2, done2, hv2;
  logic [0:0]           rda2, rdb2, hia2, hib2;
  logic [1:0][W-1:0]    loca2, locb2;
  logic [6:0]           ra2, rb2;
  logic [W-1:0]         ma2, mb2;
  logic [W:0]           mula2, mulb2;
  logic [2*W+1:0]       mulr2;
  logic [2:0]           dbg2;
  logic [W-1:0]         bx2[2], by2[2], bm2[2];
  logic [6:0]           br2[2];

  assign loca2 = {bx2[rda2], by2[rda2]};
  assign locb2 = {bx2[rdb2], by2[rdb2]};
  assign ra2   = br2[rda2];
  assign rb2   = br2[rdb2];
  assign ma2   = bm2[rda2];
  assign mb2   = bm2[rdb2];
  assign mulr2 = $signed({{(W+1){mula2[W]}}, mula2}) * $signed({{(W+1){mulb2[W]}}, mulb2});

  collision_scheduler #(.NUM_BODIES(2), .WIDTH(W)) dut2 (
    .clock(clk), .reset(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_idx_a(rda2), .rd_idx_b(rdb2), .loc_a(loca2), .loc_b(locb2),
    .radius_a(ra2), .radius_b(rb2), .mass_a(ma2), .mass_b(mb2),
    .mul_a(mula2), .mul_b(mulb2), .mul_result(mulr2),
    .hit_valid(hv2), .hit_ready(hr2), .hit_idx_a(hia2), .hit_idx_b(hib2),
    .dbg_state(dbg2)
  );

  // ---------------- 4-body instance ----------------
  logic                 start4 = 1'b0, hr4 = 1'b0;
  logic                 busy4, done4, hv4;
  logic [1:0]           rda4, rdb4, hia4, hib4;
  logic [1:0][W-1:0]    loca4, locb4;
  logic [6:0]           ra4, rb4;
  logic [W-1:0]         ma4, mb4;
  logic [W:0]           mula4, mulb4;
  logic [2*W+1:0]       mulr4;
  logic [2:0]           dbg4;
  logic [W-1:0]         bx4[4], by4[4], bm4[4];
  logic [6:0]           br4[4];

  assign loca4 = {bx4[rda4], by4[rda4]};
  assign locb4 = {bx4[rdb4], by4[rdb4]};
  assign ra4   = br4[rda4];
  assign rb4   = br4[rdb4];
  assign ma4   = bm4[rda4];
  assign mb4   = bm4[rdb4];
  assign mulr4 = $signed({{(W+1){mula4[W]}}, mula4}) * $signed({{(W+1){mulb4[W]}}, mulb4});

  collision_scheduler #(.NUM_BODIES(4), .WIDTH(W)) dut4 (
    .clock(clk), .reset(rst), .start(start4), .busy(busy4), .done(done4),
    .rd_idx_a(rda4), .rd_idx_b(rdb4), .loc_a(loca4), .loc_b(locb4),
    .radius_a(ra4), .radius_b(rb4), .mass_a(ma4), .mass_b(mb4),
    .mul_a(mula4), .mul_b(mulb4), .mul_result(mulr4),
    .hit_valid(hv4), .hit_ready(hr4), .hit_idx_a(hia4), .hit_idx_b(hib4),
    .dbg_state(dbg4)
  );

  // ---------------- reference model ----------------
  // Collision iff both bodies have mass and floor(dx^2 + dy^2) <= (ra + rb)^2 in real units.
  function automatic bit model_hit(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                   input logic [W-1:0] xb, input logic [W-1:0] yb,
                                   input logic [6:0] rad_a, input logic [6:0] rad_b,
                                   input logic [W-1:0] m_a, input logic [W-1:0] m_b);
    longint dx, dy;
    logic [127:0] d2, rr;
    int r;
    dx = longint'($signed(xa)) - longint'($signed(xb));
    dy = longint'($signed(ya)) - longint'($signed(yb));
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    d2 = 128'(dx) * 128'(dx) + 128'(dy) * 128'(dy);
    r  = int'(rad_a) + int'(rad_b);
    rr = 128'(r * r);
    return (m_a != 0) && (m_b != 0) && ((d2 >> 32) <= rr);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [6:0] r, input logic [W-1:0] m);
    bx2[k] = x; by2[k] = y; br2[k] = r; bm2[k] = m;
  endtask

  task automatic set4(input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [6:0] r, input logic [W-1:0] m);
    bx4[k] = x; by4[k] = y; br4[k] = r; bm4[k] = m;
  endtask

  // One scan of the 2-body instance; a hit is held for `hold` cycles before being accepted.
  task automatic scan2(input string name, input bit exp_hit, input int hold);
    int n, busy_n;
    n = 0; busy_n = 0;
    hr2 = 1'b0;
    start2 = 1'b1; tick; start2 = 1'b0;
    if (busy2) busy_n++;
    while (!hv2 && !done2 && n < 50) begin
      tick; n++;
      if (busy2) busy_n++;
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL %s latency: got %0d cycles, expected 5", name, n);
    end
    checks++;
    if (hv2 !== exp_hit) begin
      errors++; $display("FAIL %s hit_valid: got %b, expected %b", name, hv2, exp_hit);
    end
    if (hv2 === 1'b1) begin
      checks++;
      if ({hia2, hib2} !== 2'b01) begin
        errors++; $display("FAIL %s hit_idx: got (%0d,%0d), expected (0,1)", name, hia2, hib2);
      end
      for (int k = 0; k < hold; k++) begin
        tick;
        checks++;
        if (hv2 !== 1'b1 || {hia2, hib2} !== 2'b01) begin
          errors++; $display("FAIL %s stall cycle %0d: valid=%b idx=(%0d,%0d), expected 1 (0,1)",
                             name, k, hv2, hia2, hib2);
        end
      end
      hr2 = 1'b1; tick; hr2 = 1'b0;
      checks++;
      if (done2 !== 1'b1 || hv2 !== 1'b0) begin
        errors++; $display("FAIL %s after handshake: done=%b valid=%b, expected 1 0", name, done2, hv2);
      end
    end else begin
      checks++;
      if (done2 !== 1'b1) begin
        errors++; $display("FAIL %s done: got %b, expected 1", name, done2);
      end
      checks++;
      if (busy_n !== 5) begin
        errors++; $display("FAIL %s busy cycles: got %0d, expected 5", name, busy_n);
      end
    end
    tick;
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL %s idle after done: done=%b busy=%b, expected 0 0", name, done2, busy2);
    end
  endtask

  // One full scan of the 4-body instance with random backpressure; optionally toggles start mid-scan.
  task automatic scan4(input string name, input bit noisy_start);
    logic [3:0] exp_q[$];
    logic [3:0] exp_order[$];
    logic [3:0] obs[$];
    int cyc, busy_n, hv_n;
    bit hs, done_seen, order_ok;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        exp_order.push_back({2'(i), 2'(j)});
        if (model_hit(bx4[i], by4[i], bx4[j], by4[j], br4[i], br4[j], bm4[i], bm4[j]))
          exp_q.push_back({2'(i), 2'(j)});
      end
    end
    cyc = 0; busy_n = 0; hv_n = 0; done_seen = 1'b0;
    hr4 = 1'b0;
    start4 = 1'b1; tick; start4 = 1'b0;
    while (cyc < 2000) begin
      if (done4) begin
        done_seen = 1'b1;
        break;
      end
      if (busy4) begin
        busy_n++;
        if (obs.size() == 0 || obs[$] != {rda4, rdb4}) obs.push_back({rda4, rdb4});
      end
      if (hv4) begin
        hv_n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s unexpected hit: got (%0d,%0d), expected none", name, hia4, hib4);
        end else if ({hia4, hib4} !== exp_q[0]) begin
          errors++; $display("FAIL %s hit pair: got (%0d,%0d), expected (%0d,%0d)",
                             name, hia4, hib4, exp_q[0][3:2], exp_q[0][1:0]);
        end
      end
      hs = hv4 && hr4;
      tick; cyc++;
      if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
      hr4 = 1'($urandom_range(0, 1));
      if (noisy_start) start4 = 1'($urandom_range(0, 1));
    end
    start4 = 1'b0; hr4 = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s done: not seen within %0d cycles", name, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s missed hits: %0d unreported, expected 0", name, exp_q.size());
    end
    order_ok = (obs.size() == exp_order.size());
    for (int k = 0; k < obs.size() && k < exp_order.size(); k++)
      if (obs[k] != exp_order[k]) order_ok = 1'b0;
    checks++;
    if (!order_ok) begin
      errors++; $display("FAIL %s pair order: saw %0d pairs, first (%0d,%0d), expected 6 from (0,1)",
                         name, obs.size(), obs.size() ? obs[0][3:2] : 0, obs.size() ? obs[0][1:0] : 0);
    end
    checks++;
    if (busy_n !== 30 + hv_n) begin
      errors++; $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_n, 30 + hv_n);
    end
    tick;
    checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL %s done pulse width: done=%b busy=%b, expected 0 0", name, done4, busy4);
    end
  endtask

  task automatic far_apart4;
    for (int k = 0; k < 4; k++)
      set4(k, W'(k * 1000 * 65536), W'(k * 500 * 65536), 7'($urandom_range(0, 127)), 32'd1);
  endtask

  task automatic check_zero4(input string name);
    checks++;
    if ({busy4, done4, hv4, hia4, hib4, rda4, rdb4, mula4, mulb4, dbg4} !== '0) begin
      errors++; $display("FAIL %s outputs: busy=%b done=%b valid=%b hit=(%0d,%0d) rd=(%0d,%0d) mul=%h/%h state=%0d, expected all 0",
                         name, busy4, done4, hv4, hia4, hib4, rda4, rdb4, mula4, mulb4, dbg4);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    check_zero4("reset4");
    checks++;
    if ({busy2, done2, hv2, hia2, hib2, rda2, rdb2, mula2, mulb2, dbg2} !== '0) begin
      errors++; $display("FAIL reset2 outputs: busy=%b done=%b valid=%b rd=(%0d,%0d) mul=%h/%h, expected all 0",
                         busy2, done2, hv2, rda2, rdb2, mula2, mulb2);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy4 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL idle_no_start busy: got %b/%b, expected 0/0", busy2, busy4);
    end
  endtask

  task automatic test_touching;
    set2(0, 32'h0, 32'h0, 7'd3, 32'd1);
    set2(1, 32'h0003_0000, 32'h0004_0000, 7'd2, 32'd1);
    scan2("touching", 1'b1, 0);
  endtask

  task automatic test_miss;
    set2(0, 32'h0, 32'h0, 7'd2, 32'd1);
    set2(1, 32'h0003_0000, 32'h0004_0000, 7'd2, 32'd1);
    scan2("miss", 1'b0, 0);
  endtask

  task automatic test_inactive_signed;
    set2(0, 32'h0, 32'h0, 7'd2, 32'd1);
    set2(1, 32'hFFFE_8000, 32'hFFFE_0000, 7'd2, 32'd0);
    scan2("inactive", 1'b0, 0);
    bm2[1] = 32'd5;
    scan2("signed_backpressure", 1'b1, 10);
  endtask

  task automatic test_full_scan;
    far_apart4();
    scan4("full_far", 1'b0);
    set4(3, 32'(1000 * 65536 + 32768), 32'(500 * 65536), 7'd1, 32'd3);
    scan4("full_overlap13", 1'b0);
  endtask

  task automatic test_random;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 4; k++)
        set4(k, W'(int'($urandom_range(0, 40 * 65536)) - 20 * 65536),
             W'(int'($urandom_range(0, 40 * 65536)) - 20 * 65536),
             7'($urandom_range(0, 15)), W'($urandom_range(0, 3)));
      scan4("random4", 1'b1);
    end
    // Coordinates straddling the signed extremes force differences that need WIDTH+1 bits.
    for (int k = 0; k < 4; k++)
      set4(k, (k % 2) ? 32'h8000_0000 + W'($urandom_range(0, 255)) : 32'h7FFF_FF00 + W'($urandom_range(0, 255)),
           (k < 2) ? 32'h8000_0000 + W'($urandom_range(0, 255)) : 32'h7FFF_FF00 + W'($urandom_range(0, 255)),
           7'($urandom_range(0, 127)), 32'd1);
    scan4("extreme4", 1'b0);
    for (int s = 0; s < 6; s++) begin
      set2(0, W'(int'($urandom_range(0, 16 * 65536)) - 8 * 65536),
           W'(int'($urandom_range(0, 16 * 65536)) - 8 * 65536), 7'($urandom_range(0, 6)), 32'd1);
      set2(1, W'(int'($urandom_range(0, 16 * 65536)) - 8 * 65536),
           W'(int'($urandom_range(0, 16 * 65536)) - 8 * 65536), 7'($urandom_range(0, 6)),
           W'($urandom_range(0, 2)));
      scan2("random2", model_hit(bx2[0], by2[0], bx2[1], by2[1], br2[0], br2[1], bm2[0], bm2[1]),
            $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [W:0] exp_dy;
    far_apart4();
    set4(3, 32'(1000 * 65536 + 32768), 32'(500 * 65536), 7'd1, 32'd3);
    hr4 = 1'b0;
    start4 = 1'b1; tick; start4 = 1'b0;
    n = 0;
    while (!hv4 && n < 200) begin
      tick; n++;
    end
    checks++;
    if (hv4 !== 1'b1) begin
      errors++; $display("FAIL reset_report reach: hit_valid %b after %0d cycles, expected 1", hv4, n);
    end
    rst = 1'b1; #1;
    check_zero4("reset_in_report");
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if (done4 !== 1'b0 || hv4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL reset_report aftermath: done=%b valid=%b busy=%b, expected 0 0 0",
                           done4, hv4, busy4);
      end
    end
    exp_dy = {by4[0][W-1], by4[0]} - {by4[1][W-1], by4[1]};
    start4 = 1'b1; tick; start4 = 1'b0;
    tick; tick;
    checks++;
    if (mula4 !== exp_dy || mulb4 !== exp_dy) begin
      errors++; $display("FAIL mul_y operands: got %h/%h, expected %h", mula4, mulb4, exp_dy);
    end
    rst = 1'b1; #1;
    check_zero4("reset_in_mul_y");
    #2 rst = 1'b0;
    tick;
    scan4("rescan_after_reset", 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) set2(k, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) set4(k, '0, '0, '0, '0);
    test_reset();
    test_touching();
    test_miss();
    test_inactive_signed();
    test_full_scan();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
